// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, inverse key schedule
// computed on the fly from the round-10 key, valid/ready on both sides.
module aes_inv_cipher_iter #(
    parameter int unsigned KEY_WIDTH  = 128,
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [KEY_WIDTH-1:0] data_in,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [KEY_WIDTH-1:0] data_out,
    output logic [KEY_WIDTH-1:0] key_out
);
    localparam int unsigned RND_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [KEY_WIDTH-1:0] st, rk;
    logic [RND_W-1:0]     rnd;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] v;
        v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Inverse key schedule: recover round key rnd-1 from round key rnd
    logic [31:0]          k0, k1, k2, k3, pk0, pk1, pk2, pk3, rot_w, sub_w;
    logic [KEY_WIDTH-1:0] pk, sb, s, mix;

    assign {k0, k1, k2, k3} = rk;
    assign pk3   = k2 ^ k3;
    assign pk2   = k1 ^ k2;
    assign pk1   = k0 ^ k1;
    assign rot_w = {pk3[23:0], pk3[31:24]};
    assign pk0   = k0 ^ sub_w ^ {rcon(rnd), 24'h000000};
    assign pk    = {pk0, pk1, pk2, pk3};

    for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
        assign sub_w[8*i +: 8] = sbox_fwd(rot_w[8*i +: 8]);
    end

    // Row r of output column c comes from input column (c-r) mod 4
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sb[127-8*(4*c+r) -: 8] = sbox_inv(st[127-8*(4*((c+4-r)%4)+r) -: 8]);
        end
        assign mix[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end

    assign s = sb ^ pk;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = RUN;
            RUN:     if (rnd == RND_W'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            key_out   <= '0;
            st        <= '0;
            rk        <= '0;
            rnd       <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st  <= data_in ^ key_in;
                        rk  <= key_in;
                        rnd <= RND_W'(NUM_ROUNDS);
                    end
                end
                RUN: begin
                    st  <= (rnd > RND_W'(1)) ? mix : s;
                    rk  <= pk;
                    rnd <= rnd - RND_W'(1);
                    if (rnd == RND_W'(1)) begin
                        data_out <= s;
                        key_out  <= pk;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: a forward AES-128 model produces ciphertext
// and round-10 key; the decryptor must return the original plaintext and key.
module tb_aes_inv_cipher_iter;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] data_in, key_in, data_out, key_out;

    aes_inv_cipher_iter dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .key_out(key_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        int           acc;
    } exp_t;

    exp_t         sb_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [7:0]   sbox_t[256];
    logic [127:0] last_pt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model: forward AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    // S-box from generator-3 log walk paired with inverse walk by 3^-1
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    task automatic encrypt(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  s[16];
        logic [7:0]  t[16];
        logic [7:0]  a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox_t[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = t[b] ^ w[4*rd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    // Presents a block and waits for acceptance; keep leaves in_valid high for a follow-up send
    task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                        input logic [127:0] ok, input bit keep, output int acc);
        exp_t e;
        int   n;
        data_in  = ct;
        key_in   = k;
        in_valid = 1'b1;
        acc      = -1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            note_fail("accept_timeout");
        end else begin
            acc   = cyc + 1;
            e.pt  = pt;
            e.key = ok;
            e.acc = acc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) note_fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic         prev_ov = 1'b0;
    logic [127:0] held_d, held_k;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_ov) begin
            held_d = data_out;
            held_k = key_out;
            if (sb_q.size() == 0) note_fail("unexpected_out_valid");
            else chk("latency", 128'(cyc - sb_q[0].acc), 128'(10));
        end else if (out_valid && prev_ov) begin
            chk("hold_data", data_out, held_d);
            chk("hold_key", key_out, held_k);
        end
        if (out_valid) chk("in_ready_low_while_done", 128'(in_ready), 128'(0));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                note_fail("pop_empty_scoreboard");
            end else begin
                e = sb_q.pop_front();
                chk("data_out", data_out, e.pt);
                chk("key_out", key_out, e.key);
            end
        end
        prev_ov = out_valid;
    end

    // ---------------- main sequence ----------------
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [127:0] pt1, key1, ct1, k1, pt2, key2, ct2, k2;
        int           acc1, acc2, n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        key_in    = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_data_out", data_out, 128'(0));
        chk("reset_key_out", key_out, 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Known-answer vectors
        send(C1_CT, C1_K10, C1_PT, C1_KEY, 1'b0, acc1);
        drain();
        send(B_CT, B_K10, B_PT, B_KEY, 1'b0, acc1);
        drain();

        // Backpressure: result held 20 cycles, stray in_valid ignored
        out_ready = 1'b0;
        send(C1_CT, C1_K10, C1_PT, C1_KEY, 1'b0, acc1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) note_fail("out_valid_timeout");
        for (int h = 0; h < 20; h++) begin
            @(posedge clk);
            #1;
            if (h == 5) begin
                in_valid = 1'b1;
                data_in  = rand128();
                key_in   = rand128();
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;

        // Reset in the middle of round 5 discards the block
        send(C1_CT, C1_K10, C1_PT, C1_KEY, 1'b0, acc1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_in_ready", 128'(in_ready), 128'(1));
        chk("midreset_out_valid", 128'(out_valid), 128'(0));
        chk("midreset_data_out", data_out, 128'(0));
        chk("midreset_key_out", key_out, 128'(0));
        repeat (12) begin
            @(negedge clk);
            chk("midreset_quiet", 128'(out_valid), 128'(0));
        end
        @(posedge clk);
        #1;
        send(C1_CT, C1_K10, C1_PT, C1_KEY, 1'b0, acc1);
        drain();

        // Back-to-back with in_valid held high
        pt1 = rand128(); key1 = rand128();
        pt2 = rand128(); key2 = rand128();
        encrypt(pt1, key1, ct1, k1);
        encrypt(pt2, key2, ct2, k2);
        send(ct1, k1, pt1, key1, 1'b1, acc1);
        send(ct2, k2, pt2, key2, 1'b0, acc2);
        chk("b2b_accept_spacing", 128'(acc2 - acc1), 128'(12));
        drain();

        // Loopback through the forward model with random blocks and keys
        for (int i = 0; i < 16; i++) begin
            pt1  = rand128();
            key1 = rand128();
            encrypt(pt1, key1, ct1, k1);
            send(ct1, k1, pt1, key1, 1'b0, acc1);
            last_pt = pt1;
            drain();
        end
        repeat (2) @(negedge clk);
        chk("retain_data_out", data_out, last_pt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption core; the inverse of the team's unrolled encryption core.
- Takes a ciphertext and the final (round-10) round key, which is the key output of the encryption core.
- Runs the inverse key schedule on the fly, executing one inverse round per clock.
- Returns the plaintext and the recovered original cipher key through a valid/ready handshake.
- Sits between the ciphertext source and the plaintext consumer.

Parameters:
- KEY_WIDTH, 128: key/data width. Only 128 is supported.
- NUM_ROUNDS, 10: AES-128 round count. Fixed; other values are unsupported.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: ciphertext/key present.
- in_ready, output, 1: core idle, can accept.
- data_in, input, 128: ciphertext, byte 0 in [127:120].
- key_in, input, 128: round-10 round key, same byte order.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- data_out, output, 128: plaintext.
- key_out, output, 128: recovered round-0 key (the original cipher key).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values, applied at any clk edge with reset=1, including mid-operation:
  - state=IDLE, in_ready=1, out_valid=0.
  - data_out=0, key_out=0, round counter=0.
  - Any in-flight block is discarded.
- States and transitions:
  - IDLE → RUN on in_valid & in_ready.
  - RUN → RUN while rnd>1.
  - RUN → DONE when rnd=1.
  - DONE → IDLE on out_ready.
- Accept edge (IDLE, in_valid=1):
  - st ← data_in ^ key_in; rk ← key_in; rnd ← 10; in_ready drops next cycle.
- RUN cycle with counter rnd (10 down to 1):
  - pk = previous round key derived from rk, with words k0..k3 (k0 = [127:96]):
    - pk3 = k2^k3; pk2 = k1^k2; pk1 = k0^k1.
    - pk0 = k0 ^ SubWord(RotWord(pk3)) ^ Rcon(rnd).
    - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the top byte, low bytes 0.
  - s = InvSubBytes(InvShiftRows(st)) ^ pk.
  - st ← (rnd>1) ? InvMixColumns(s) : s; rk ← pk; rnd ← rnd-1.
- InvShiftRows: row r is rotated right by r byte positions. Column-major state with byte 0 at [127:120], so:
  - out[119:112] = in[23:16].
  - out[111:104] = in[47:40].
  - out[103:96] = in[71:64].
- InvMixColumns uses coefficients 0e,0b,0d,09 in GF(2^8) mod x^8+x^4+x^3+x+1.
- S-boxes:
  - Forward S-box (key schedule only) and inverse S-box (data path) are computed in logic: GF inverse plus affine/inverse-affine.
  - No ROM files.
  - 4 forward and 16 inverse S-box instances; all combinational within one cycle.
- Completion: on the rnd=1 edge, data_out ← st result and key_out ← pk; out_valid=1 from the next cycle.
- Latency: out_valid asserts exactly 10 cycles after the accept edge.
- Output hold: out_valid, data_out and key_out stay stable until the edge where out_ready=1.
  - That edge clears out_valid and sets in_ready=1 next cycle.
  - data_out and key_out retain their last values after the handshake.
- If out_ready is already high when out_valid rises, the handshake completes on the first out_valid cycle.
- in_valid is ignored while in RUN or DONE; no queuing.
- Throughput: one block per 12 cycles minimum (accept, 10 rounds, handshake).
- A held in_valid on the cycle in_ready returns is accepted then.

Test Plan:
- FIPS-197 C.1: data_in=69c4e0d86a7b0430d8cdb78070b4c55a, key_in=13111d7fe3944a17f307a78b4d2b30c5.
  - Expect, 10 cycles after accept: data_out=00112233445566778899aabbccddeeff, key_out=000102030405060708090a0b0c0d0e0f.
- FIPS-197 App.B: data_in=3925841d02dc09fbdc118597196a0b32, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Expect data_out=3243f6a8885a308d313198a2e0370734, key_out=2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - Expect outputs stable and in_ready=0 throughout.
  - A second in_valid pulse at cycle 5 of the hold is ignored.
  - Release out_ready → in_ready=1 next cycle.
- Reset at round 5: assert reset for one cycle.
  - Expect in_ready=1, out_valid=0, data_out=0 next cycle.
  - A fresh C.1 vector then decrypts correctly.
- Back-to-back: in_valid held high with out_ready=1 and two vectors queued.
  - Second accept occurs on the cycle in_ready returns; both results are correct.
- Loopback: encrypt 16 random blocks/keys with the encryption core, then feed its dataOut/keyOut in.
  - Expect the original plaintext and key back.
